uart_rx_frame_ctrl: RTL and testbench

- Sequences the UART receiver output into framed packets: SOF, LEN, payload, XOR checksum.
- Buffers the payload and releases it downstream on a valid/ready stream only after the checksum passes.
- Reports framing, length, checksum, overrun and inter-byte timeout errors.
- Sits directly behind uart_rx and consumes its rx_data/rx_ready/rx_error/rx_idle outputs.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_frame_ctrl_if.sv | 25 ++
 rtl/uart_edge_det.sv | 19 +
 rtl/uart_rx_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framing controller.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        DRAIN
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_FRAMING  = 3'd1,
        ERR_LENGTH   = 3'd2,
        ERR_CHECKSUM = 3'd3,
        ERR_OVERRUN  = 3'd4,
        ERR_TIMEOUT  = 3'd5
    } err_t;

    localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Receiver-side inputs, payload stream and status outputs of the framing controller.
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic       rx_idle;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [2:0] err_code;
    logic       busy;

    modport slave (
        input  rx_data, rx_ready, rx_error, rx_idle, out_ready,
        output out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
    );

    modport master (
        output rx_data, rx_ready, rx_error, rx_idle, out_ready,
        input  out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_edge_det.sv
// Rising-edge detector for a uart_rx level flag; pulse is combinational in the rising cycle.
module uart_edge_det (
    input  logic clk50m,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic d_q;
    logic d_d;

    always_comb d_d = d;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames uart_rx bytes as SOF/LEN/payload/XOR and streams the payload only after the checksum passes.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [7:0]  SOF_BYTE    = DEF_SOF_BYTE,
    parameter int unsigned TIMEOUT_CYC = 50_000
) (
    input logic                 clk50m,
    input logic                 rst_n,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam int unsigned   IW       = $clog2(MAX_LEN + 1);
    localparam int unsigned   AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned   GW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT_CYC);
    localparam logic [GW-1:0] GAP_TRIP = GW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    chk_q, chk_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    err_t          err_code_q, err_code_d;
    logic [7:0]    mem_q [MAX_LEN];
    logic          mem_we;

    logic byte_ev, err_ev, in_frame, timeout_hit, last_rd, xfer;

    uart_edge_det u_ready_edge (.clk50m(clk50m), .rst_n(rst_n), .d(bus.rx_ready), .rise(byte_ev));
    uart_edge_det u_error_edge (.clk50m(clk50m), .rst_n(rst_n), .d(bus.rx_error), .rise(err_ev));

    assign in_frame    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    assign timeout_hit = in_frame && bus.rx_idle && (gap_q == GAP_TRIP);
    assign last_rd     = (rd_idx_q == len_q - IW'(1));
    assign xfer        = (state_q == DRAIN) && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        chk_d       = chk_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        mem_we      = 1'b0;

        if (!in_frame || byte_ev)                      gap_d = '0;
        else if (bus.rx_idle && (gap_q != GAP_MAX))    gap_d = gap_q + GW'(1);
        else                                           gap_d = gap_q;

        unique case (state_q)
            HUNT: begin
                if (byte_ev && !err_ev && (bus.rx_data == SOF_BYTE)) state_d = LEN;
            end
            LEN, PAYLOAD, CHK: begin
                // Priority inside a frame: stop-bit error, then the byte, then the idle timeout.
                if (err_ev) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_FRAMING;
                    state_d     = HUNT;
                end else if (byte_ev) begin
                    if (state_q == LEN) begin
                        if ((bus.rx_data == 8'd0) || (bus.rx_data > LEN_MAX)) begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_LENGTH;
                            state_d     = HUNT;
                        end else begin
                            len_d    = bus.rx_data[IW-1:0];
                            chk_d    = bus.rx_data;
                            wr_idx_d = '0;
                            state_d  = PAYLOAD;
                        end
                    end else if (state_q == PAYLOAD) begin
                        mem_we   = 1'b1;
                        chk_d    = chk_q ^ bus.rx_data;
                        wr_idx_d = wr_idx_q + IW'(1);
                        if (wr_idx_q == len_q - IW'(1)) state_d = CHK;
                    end else if (bus.rx_data == chk_q) begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = '0;
                        state_d    = DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHECKSUM;
                        state_d     = HUNT;
                    end
                end else if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = HUNT;
                end
            end
            DRAIN: begin
                if (byte_ev) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (xfer) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (last_rd) state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            gap_q       <= '0;
            chk_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            gap_q       <= gap_d;
            chk_q       <= chk_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload storage needs no reset: it is only read in DRAIN after a full frame was written.
    always_ff @(posedge clk50m) begin
        if (mem_we) mem_q[wr_idx_q[AW-1:0]] <= bus.rx_data;
    end

    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = (state_q == DRAIN) ? mem_q[rd_idx_q[AW-1:0]] : '0;
    assign bus.out_last  = (state_q == DRAIN) && last_rd;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state_q != HUNT);
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: payload and error codes are queued as frames are sent.
module tb_uart_rx_frame_ctrl;
    import uart_pkg::*;

    logic clk50m = 1'b0;
    logic rst_n  = 1'b0;
    always #10 clk50m = ~clk50m;

    uart_rx_frame_ctrl_if bus ();

    uart_rx_frame_ctrl #(
        .MAX_LEN    (16),
        .SOF_BYTE   (8'hA5),
        .TIMEOUT_CYC(50_000)
    ) dut (
        .clk50m(clk50m),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ok_cnt   = 0;
    logic [8:0]  exp_q [$];
    logic [2:0]  err_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic       prev_valid, prev_ready, prev_err, prev_xfer_mid;
    logic [7:0] prev_data;
    logic [8:0] mon_e;
    logic [2:0] mon_ec;

    always @(negedge clk50m) begin
        if (rst_n) begin
            if (bus.frame_ok) begin
                ok_cnt++;
                check("ok_with_valid", bus.out_valid, 1);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_data_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_e[7:0]);
                    check("out_last", bus.out_last, mon_e[8]);
                end
            end
            if (prev_valid && !prev_ready && bus.out_valid) check("hold_data", bus.out_data, prev_data);
            if (prev_xfer_mid && bus.out_ready) check("drain_gap", bus.out_valid, 1);
            if (prev_err) check("err_one_cycle", bus.frame_err, 0);
            if (bus.frame_err) begin
                check("sb_err_avail", err_q.size() != 0, 1);
                if (err_q.size() != 0) begin
                    mon_ec = err_q.pop_front();
                    check("err_code", bus.err_code, mon_ec);
                end
            end
            prev_valid    <= bus.out_valid;
            prev_ready    <= bus.out_ready;
            prev_data     <= bus.out_data;
            prev_err      <= bus.frame_err;
            prev_xfer_mid <= bus.out_valid && bus.out_ready && !bus.out_last;
        end else begin
            prev_valid    <= 1'b0;
            prev_ready    <= 1'b0;
            prev_data     <= '0;
            prev_err      <= 1'b0;
            prev_xfer_mid <= 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk50m);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        @(negedge clk50m);
        bus.rx_ready = 1'b0;
        repeat (2) @(negedge clk50m);
    endtask

    task automatic send_frame(input logic [7:0] n, input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input bit corrupt);
        logic [7:0] p [3];
        logic [7:0] c;
        p[0] = p0; p[1] = p1; p[2] = p2;
        c = n;
        for (int i = 0; i < n; i++) c ^= p[i];
        if (corrupt) err_q.push_back(3'd3);
        else for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), p[i]});
        send_byte(8'hA5);
        send_byte(n);
        for (int i = 0; i < n; i++) send_byte(p[i]);
        send_byte(corrupt ? c + 8'd1 : c);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            @(negedge clk50m);
        end
        check(tag, bus.busy, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int unsigned ok0, cnt;
    bit          found;

    initial begin
        bus.rx_data   = '0;
        bus.rx_ready  = 1'b0;
        bus.rx_error  = 1'b0;
        bus.rx_idle   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk50m);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ok", bus.frame_ok, 0);
        check("rst_err", bus.frame_err, 0);
        check("rst_code", bus.err_code, 0);
        rst_n = 1'b1;
        @(negedge clk50m);

        // Good 3-byte frame after a stray byte.
        ok0 = ok_cnt;
        send_byte(8'h5A);
        check("hunt_ignore", bus.busy, 0);
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 1'b0);
        wait_idle("t1_idle");
        check("t1_ok_cnt", ok_cnt - ok0, 1);
        check("t1_code", bus.err_code, 0);

        // Bad checksum.
        ok0 = ok_cnt;
        send_frame(8'd3, 8'h11, 8'h22, 8'h33, 1'b1);
        wait_idle("t2_idle");
        check("t2_code", bus.err_code, 3);
        check("t2_ok_cnt", ok_cnt - ok0, 0);

        // Length 0 and length 17, then a single-byte frame.
        err_q.push_back(3'd2);
        send_byte(8'hA5);
        send_byte(8'h00);
        wait_idle("t3a_idle");
        err_q.push_back(3'd2);
        send_byte(8'hA5);
        send_byte(8'h11);
        wait_idle("t3b_idle");
        ok0 = ok_cnt;
        send_frame(8'd1, 8'h7E, 8'h00, 8'h00, 1'b0);
        wait_idle("t3c_idle");
        check("t3_ok_cnt", ok_cnt - ok0, 1);
        check("t3_code_hold", bus.err_code, 2);

        // Inter-byte timeout measured from the 0x11 byte event.
        err_q.push_back(3'd5);
        send_byte(8'hA5);
        send_byte(8'h02);
        @(negedge clk50m);
        bus.rx_data  = 8'h11;
        bus.rx_ready = 1'b1;
        bus.rx_idle  = 1'b1;
        @(posedge clk50m);
        cnt   = 0;
        found = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk50m);
            cnt++;
            #1;
            if (bus.frame_err) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_found", found, 1);
        check("t4_latency", cnt, 50000);
        @(negedge clk50m);
        bus.rx_ready = 1'b0;
        bus.rx_idle  = 1'b0;
        check("t4_busy", bus.busy, 0);
        check("t4_code", bus.err_code, 5);

        // Stalled drain with an overrun byte.
        bus.out_ready = 1'b0;
        send_frame(8'd2, 8'hAA, 8'hBB, 8'h00, 1'b0);
        repeat (2) @(negedge clk50m);
        check("t5_valid", bus.out_valid, 1);
        check("t5_data", bus.out_data, 8'hAA);
        err_q.push_back(3'd4);
        send_byte(8'hA5);
        check("t5_data_hold", bus.out_data, 8'hAA);
        check("t5_busy", bus.busy, 1);
        check("t5_code", bus.err_code, 4);
        bus.out_ready = 1'b1;
        wait_idle("t5_idle");

        // Stop-bit error mid-frame.
        err_q.push_back(3'd1);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        @(negedge clk50m);
        bus.rx_error = 1'b1;
        repeat (2) @(negedge clk50m);
        bus.rx_error = 1'b0;
        wait_idle("t6_idle");
        check("t6_code", bus.err_code, 1);

        // Reset mid-frame.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        check("t7_busy_pre", bus.busy, 1);
        @(negedge clk50m);
        rst_n = 1'b0;
        #1;
        check("t7_busy", bus.busy, 0);
        check("t7_valid", bus.out_valid, 0);
        check("t7_err", bus.frame_err, 0);
        check("t7_code", bus.err_code, 0);
        check("t7_ok", bus.frame_ok, 0);
        @(negedge clk50m);
        rst_n = 1'b1;
        repeat (5) @(negedge clk50m);
        check("t7_busy_post", bus.busy, 0);
        check("t7_code_post", bus.err_code, 0);

        check("sb_data_drained", exp_q.size(), 0);
        check("sb_err_drained", err_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
